// File: rtl/pc_select.sv
// Fetch-address generator: owns the fetch PC, defers redirects while ibus is busy.
// Optional perf counters are enabled by defining PC_SELECT_PERF_CNT_EN.
module pc_select #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pc_seq_i,
    input  logic        fetch_busy_i,
    input  logic        stall_i,
    input  logic        br_valid_i,
    input  logic [31:0] br_target_i,
    input  logic        exc_valid_i,
    input  logic [31:0] exc_target_i,
    input  logic        cp0_int_i,
    output logic [31:0] pc_o,
    output logic        int_o,
    output logic        kill_o,
    output logic        pend_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] redir_cnt_o
);

    typedef enum logic {NONE, PEND} pend_state_t;

    pend_state_t state, state_nxt;
    logic [31:0] pend_target, pend_target_nxt;
    logic        pend_exc, pend_exc_nxt;
    logic        pend_live_exc, pend_live_br, exc_sel, adv, redirect;
    logic [31:0] pc_nxt;

    always_comb begin
        pend_live_exc = (state == PEND) && pend_exc;
        pend_live_br  = (state == PEND) && !pend_exc;
        exc_sel       = exc_valid_i || pend_live_exc;
        adv           = !fetch_busy_i && (!stall_i || exc_sel);

        pc_nxt   = pc_seq_i;
        redirect = 1'b1;
        if (exc_valid_i)        pc_nxt = exc_target_i;
        else if (pend_live_exc) pc_nxt = pend_target;
        else if (br_valid_i)    pc_nxt = br_target_i;
        else if (pend_live_br)  pc_nxt = pend_target;
        else                    redirect = 1'b0;

        state_nxt       = state;
        pend_target_nxt = pend_target;
        pend_exc_nxt    = pend_exc;
        // Capture only while fetch is busy or something is already pending;
        // a pending exception locks out later branches.
        if (adv) begin
            state_nxt = NONE;
        end else if (exc_valid_i && (fetch_busy_i || state == PEND)) begin
            state_nxt       = PEND;
            pend_target_nxt = exc_target_i;
            pend_exc_nxt    = 1'b1;
        end else if (br_valid_i && !pend_live_exc && (fetch_busy_i || state == PEND)) begin
            state_nxt       = PEND;
            pend_target_nxt = br_target_i;
            pend_exc_nxt    = 1'b0;
        end

        // A pending exception always advances on the first non-busy cycle,
        // so this is exactly the busy-fall cycle or a direct idle exception.
        kill_o = !fetch_busy_i && exc_sel;
        pend_o = (state == PEND);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= NONE;
            pend_target <= '0;
            pend_exc    <= 1'b0;
            pc_o        <= RESET_PC;
            int_o       <= 1'b0;
        end else begin
            state       <= state_nxt;
            pend_target <= pend_target_nxt;
            pend_exc    <= pend_exc_nxt;
            if (adv) begin
                pc_o  <= pc_nxt;
                int_o <= cp0_int_i;
            end
        end
    end

`ifdef PC_SELECT_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cnt_o <= '0;
            redir_cnt_o <= '0;
        end else begin
            if (!adv)            stall_cnt_o <= stall_cnt_o + 32'd1;
            if (adv && redirect) redir_cnt_o <= redir_cnt_o + 32'd1;
        end
    end
`else
    assign stall_cnt_o = '0;
    assign redir_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pc_select.sv
// Directed bench for pc_select; expected post-edge state is queued per step and checked after the edge.
module tb_pc_select;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] pc_seq_i;
    logic        fetch_busy_i, stall_i, br_valid_i, exc_valid_i, cp0_int_i;
    logic [31:0] br_target_i, exc_target_i;
    logic [31:0] pc_o, stall_cnt_o, redir_cnt_o;
    logic        int_o, kill_o, pend_o;

    int checks = 0;
    int failures = 0;
    int n_stall = 0;
    int n_redir = 0;

    typedef struct {
        logic [31:0] pc;
        logic        intr;
        logic        pend;
        logic [31:0] sc;
        logic [31:0] rc;
    } exp_t;
    exp_t q[$];

    pc_select #(.RESET_PC(32'hbfc0_0000)) dut (
        .clk(clk), .resetn(resetn), .pc_seq_i(pc_seq_i),
        .fetch_busy_i(fetch_busy_i), .stall_i(stall_i),
        .br_valid_i(br_valid_i), .br_target_i(br_target_i),
        .exc_valid_i(exc_valid_i), .exc_target_i(exc_target_i),
        .cp0_int_i(cp0_int_i), .pc_o(pc_o), .int_o(int_o),
        .kill_o(kill_o), .pend_o(pend_o),
        .stall_cnt_o(stall_cnt_o), .redir_cnt_o(redir_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic drv(input logic busy, input logic stall, input logic br, input logic [31:0] brt,
                       input logic exc, input logic [31:0] exct, input logic intr, input logic [31:0] seq);
        fetch_busy_i = busy; stall_i = stall;
        br_valid_i = br; br_target_i = brt;
        exc_valid_i = exc; exc_target_i = exct;
        cp0_int_i = intr; pc_seq_i = seq;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_post();
        exp_t e;
        if (q.size() == 0) begin
            checks++; failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = q.pop_front();
        chk32("pc_o", pc_o, e.pc);
        chk32("int_o", {31'd0, int_o}, {31'd0, e.intr});
        chk32("pend_o", {31'd0, pend_o}, {31'd0, e.pend});
        chk32("stall_cnt_o", stall_cnt_o, e.sc);
        chk32("redir_cnt_o", redir_cnt_o, e.rc);
    endtask

    // k: kill before the edge; p/i/pd: state after the edge; s/r: stall / redirect cycle
    task automatic step(input logic k, input logic [31:0] p, input logic i, input logic pd,
                        input logic s, input logic r);
        exp_t e;
        #1;
        chk32("kill_o", {31'd0, kill_o}, {31'd0, k});
        if (s) n_stall++;
        if (r) n_redir++;
        e.pc = p; e.intr = i; e.pend = pd;
`ifdef PC_SELECT_PERF_CNT_EN
        e.sc = n_stall; e.rc = n_redir;
`else
        e.sc = '0; e.rc = '0;
`endif
        q.push_back(e);
        @(posedge clk); #1;
        check_post();
    endtask

    initial begin
        resetn = 1'b0;
        drv(0, 0, 0, '0, 0, '0, 0, 32'hbfc0_0004);
        @(posedge clk); @(posedge clk); #1;
        // reset state
        q.push_back('{32'hbfc0_0000, 1'b0, 1'b0, 32'd0, 32'd0});
        check_post();
        chk32("kill_reset", {31'd0, kill_o}, 32'd0);
        resetn = 1'b1;

        // sequential fetch
        drv(0, 0, 0, '0, 0, '0, 0, 32'hbfc0_0004); step(0, 32'hbfc0_0004, 0, 0, 0, 0);
        drv(0, 0, 0, '0, 0, '0, 0, 32'hbfc0_0008); step(0, 32'hbfc0_0008, 0, 0, 0, 0);
        // idle branch, int sampled with it
        drv(0, 0, 1, 32'h8000_1000, 0, '0, 1, 32'hbfc0_000c); step(0, 32'h8000_1000, 1, 0, 0, 1);
        // branch while busy: deferred until busy falls, delay slot not killed
        drv(1, 0, 1, 32'h8000_3000, 0, '0, 0, 32'h8000_1004); step(0, 32'h8000_1000, 1, 1, 1, 0);
        for (int c = 0; c < 3; c++) begin
            drv(1, 0, 0, '0, 0, '0, 0, 32'h8000_1004); step(0, 32'h8000_1000, 1, 1, 1, 0);
        end
        drv(0, 0, 0, '0, 0, '0, 0, 32'h8000_1004); step(0, 32'h8000_3000, 0, 0, 0, 1);
        // pending branch overwritten by exception; later branch ignored
        drv(1, 0, 1, 32'h8000_5000, 0, '0, 0, 32'h8000_3004); step(0, 32'h8000_3000, 0, 1, 1, 0);
        drv(1, 0, 0, '0, 1, 32'hbfc0_0380, 0, 32'h8000_3004); step(0, 32'h8000_3000, 0, 1, 1, 0);
        drv(1, 0, 1, 32'h8000_6000, 0, '0, 0, 32'h8000_3004); step(0, 32'h8000_3000, 0, 1, 1, 0);
        drv(0, 0, 0, '0, 0, '0, 1, 32'h8000_3004); step(1, 32'hbfc0_0380, 1, 0, 0, 1);
        drv(0, 0, 0, '0, 0, '0, 0, 32'hbfc0_0384); step(0, 32'hbfc0_0384, 0, 0, 0, 0);
        // exception overrides stall
        drv(0, 1, 0, '0, 1, 32'hbfc0_0380, 1, 32'hbfc0_0388); step(1, 32'hbfc0_0380, 1, 0, 0, 1);
        for (int c = 0; c < 3; c++) begin
            drv(0, 1, 0, '0, 0, '0, 0, 32'hbfc0_0384); step(0, 32'hbfc0_0380, 1, 0, 1, 0);
        end
        // stall + busy: branch latches, held through stall, applied after
        drv(1, 1, 1, 32'h8000_7000, 0, '0, 0, 32'hbfc0_0384); step(0, 32'hbfc0_0380, 1, 1, 1, 0);
        drv(0, 1, 0, '0, 0, '0, 0, 32'hbfc0_0384); step(0, 32'hbfc0_0380, 1, 1, 1, 0);
        drv(0, 0, 0, '0, 0, '0, 0, 32'hbfc0_0384); step(0, 32'h8000_7000, 0, 0, 0, 1);
        // simultaneous exception and branch: exception wins
        drv(0, 0, 1, 32'h8000_8000, 1, 32'h8000_0180, 1, 32'h8000_7004); step(1, 32'h8000_0180, 1, 0, 0, 1);
        // redirect on busy-fall cycle applies directly
        drv(1, 0, 0, '0, 0, '0, 0, 32'h8000_0184); step(0, 32'h8000_0180, 1, 0, 1, 0);
        drv(0, 0, 1, 32'h8000_9000, 0, '0, 0, 32'h8000_0184); step(0, 32'h8000_9000, 0, 0, 0, 1);
        // pending redirect discarded by reset
        drv(1, 0, 1, 32'h8000_a000, 0, '0, 0, 32'h8000_9004); step(0, 32'h8000_9000, 0, 1, 1, 0);
        resetn = 1'b0;
        n_stall = 0; n_redir = 0;
        drv(0, 0, 0, '0, 0, '0, 1, 32'h8000_9004); step(0, 32'hbfc0_0000, 0, 0, 0, 0);
        resetn = 1'b1;
        drv(0, 0, 0, '0, 0, '0, 0, 32'hbfc0_0004); step(0, 32'hbfc0_0004, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
